// File: rtl/riscv_pkg.sv
// Shared core definitions: RV32I load/store funct3 encodings and the data-memory FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Access decode for the data memory: byte enables and fault detection,
// store lane replication, and load lane extraction with sign/zero extension.
module mem_align
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic        is_read,
  input  logic        is_write,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic        err,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [3:0]  be_raw;
  logic        bad_f3;
  logic        misalign;
  logic        oob;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Size decode and alignment per funct3
  always_comb begin
    be_raw   = 4'b0000;
    bad_f3   = 1'b0;
    misalign = 1'b0;
    wlane    = 32'd0;
    unique case (funct3)
      F3_B, F3_BU: begin
        be_raw = 4'b0001 << addr[1:0];
        wlane  = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be_raw   = addr[1] ? 4'b1100 : 4'b0011;
        misalign = addr[0];
        wlane    = {2{wdata[15:0]}};
      end
      F3_W: begin
        be_raw   = 4'b1111;
        misalign = (addr[1:0] != 2'b00);
        wlane    = wdata;
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  assign oob = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
  assign err = (is_read == is_write) || bad_f3 || (is_write && funct3[2]) || misalign || oob;
  assign be  = err ? 4'b0000 : be_raw;

  // Load lane extraction and extension
  always_comb begin
    byte_sel = 8'd0;
    half_sel = addr[1] ? rword[31:16] : rword[15:0];
    rdata    = 32'd0;
    unique case (addr[1:0])
      2'd0: byte_sel = rword[7:0];
      2'd1: byte_sel = rword[15:8];
      2'd2: byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    if (is_read && !err) begin
      unique case (funct3)
        F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
        F3_BU:   rdata = {24'd0, byte_sel};
        F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
        F3_HU:   rdata = {16'd0, half_sel};
        default: rdata = rword;
      endcase
    end
  end

endmodule

// File: rtl/data_mem.sv
// Data-memory responder: single outstanding access over valid/ready, programmable
// wait states, byte/half/word loads and stores on an internal word array.
module data_mem
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        is_memread_i,
  input  logic        is_memwrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               rd_q;
  logic               wr_q;
  logic [2:0]         f3_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept_c;
  logic               access_c;
  logic               we_c;
  logic [IDX_W-1:0]   idx_c;
  logic [3:0]         be_c;
  logic               err_c;
  logic [31:0]        wlane_c;
  logic [31:0]        rdata_c;

  assign accept_c = (state == IDLE) && req_valid_i;
  assign access_c = (state == ACCESS) && (cnt == '0);
  assign idx_c    = addr_q[IDX_W+1:2];
  // Reset gating keeps a write from landing on an edge where reset is asserted
  assign we_c     = access_c && wr_q && !err_c && !rst_i;

  mem_align #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_align (
    .funct3  (f3_q),
    .addr    (addr_q),
    .is_read (rd_q),
    .is_write(wr_q),
    .wdata   (wdata_q),
    .rword   (mem[idx_c]),
    .be      (be_c),
    .err     (err_c),
    .wlane   (wlane_c),
    .rdata   (rdata_c)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid_i) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = RESP;
      RESP:    if (resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state)
      IDLE:    req_ready_o  = 1'b1;
      RESP:    resp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      if (accept_c) begin
        cnt     <= CNT_W'(WAIT_CYCLES);
        rd_q    <= is_memread_i;
        wr_q    <= is_memwrite_i;
        f3_q    <= funct3_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end else if ((state == ACCESS) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access_c) begin
        rdata_o <= rdata_c;
        err_o   <= err_c;
      end
    end
  end

  // Storage array, not reset; byte-lane writes
  always_ff @(posedge clk_i) begin
    if (we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[idx_c][8*b +: 8] <= wlane_c[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: byte-addressed reference model, per-cycle
// output comparison, and directed accesses with literal expected results.
module tb_data_mem;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAIT  = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_memread;
  logic        is_memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] rdata;
  logic        err;

  data_mem #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .is_memread_i (is_memread),
    .is_memwrite_i(is_memwrite),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .rdata_o      (rdata),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory plus expected response of the outstanding access
  logic [7:0]  mbytes [4*DEPTH];
  bit          busy = 1'b0;
  int          resp_at = 0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;

  task automatic model_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rv, output logic ev);
    int sz;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ev = (rd == wr) || (f3 == 3'b011) || (f3[2:1] == 2'b11) || (wr && f3[2]) ||
         ((a % sz) != 0) || ((a >> 2) >= DEPTH);
    rv = 32'd0;
    if (!ev && wr) for (int i = 0; i < sz; i++) mbytes[a+i] = wd[8*i +: 8];
    if (!ev && rd) begin
      for (int i = 0; i < sz; i++) rv[8*i +: 8] = mbytes[a+i];
      if (!f3[2] && sz < 4 && rv[8*sz-1])
        for (int i = sz; i < 4; i++) rv[8*i +: 8] = 8'hFF;
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("resp_valid", 32'(resp_valid), 32'(busy && (cyc >= resp_at)));
      if (busy && (cyc >= resp_at)) begin
        chk("rdata", rdata, exp_rdata);
        chk("err", 32'(err), 32'(exp_err));
      end
    end
  end

  // One access; called just after a rising edge with the DUT idle
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] got, output logic got_err);
    logic [31:0] er;
    logic        ee;
    int          n;
    req_valid   = 1'b1;
    is_memread  = rd;
    is_memwrite = wr;
    funct3      = f3;
    addr        = a;
    wdata       = wd;
    resp_ready  = (hold == 0);
    @(posedge clk); #1;
    model_access(rd, wr, f3, a, wd, er, ee);
    exp_rdata = er;
    exp_err   = ee;
    resp_at   = cyc + WAIT + 1;
    busy      = 1'b1;
    req_valid = 1'b0;
    addr      = ~a;
    wdata     = ~wd;
    funct3    = ~f3;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout actual=none required=resp_valid within 40 cycles");
      busy = 1'b0;
      got = 32'd0;
      got_err = 1'b0;
      return;
    end
    chk("latency", 32'(n), 32'(WAIT + 1));
    got     = rdata;
    got_err = err;
    if (hold > 0) begin
      // A competing store offered while the response is stalled must be ignored
      req_valid   = 1'b1;
      is_memread  = 1'b0;
      is_memwrite = 1'b1;
      funct3      = F3_W;
      addr        = 32'h10;
      wdata       = 32'h0BADF00D;
      repeat (hold) begin
        @(posedge clk); #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    busy = 1'b0;
  endtask

  logic [31:0] g;
  logic        ge;

  initial begin
    for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; is_memread = 1'b0; is_memwrite = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0; resp_ready = 1'b1;
    #7;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    access(0, 1, F3_W, 32'h10, 32'hDEADBEEF, 0, g, ge);
    chk("sw_rdata", g, 32'd0);
    chk("sw_err", 32'(ge), 32'd0);
    access(1, 0, F3_W, 32'h10, 32'd0, 0, g, ge);
    chk("lw_10", g, 32'hDEADBEEF);
    chk("lw_10_err", 32'(ge), 32'd0);
    access(1, 0, F3_B, 32'h13, 32'd0, 0, g, ge);
    chk("lb_13", g, 32'hFFFFFFDE);
    access(1, 0, F3_BU, 32'h13, 32'd0, 0, g, ge);
    chk("lbu_13", g, 32'h000000DE);
    access(1, 0, F3_H, 32'h12, 32'd0, 0, g, ge);
    chk("lh_12", g, 32'hFFFFDEAD);
    access(1, 0, F3_HU, 32'h10, 32'd0, 0, g, ge);
    chk("lhu_10", g, 32'h0000BEEF);

    access(0, 1, F3_B, 32'h11, 32'h00000055, 0, g, ge);
    access(1, 0, F3_W, 32'h10, 32'd0, 0, g, ge);
    chk("lw_after_sb", g, 32'hDEAD55EF);

    access(1, 0, F3_W, 32'h12, 32'd0, 0, g, ge);
    chk("lw_misalign_err", 32'(ge), 32'd1);
    chk("lw_misalign_rdata", g, 32'd0);
    access(0, 1, F3_H, 32'h11, 32'hFFFF1234, 0, g, ge);
    chk("sh_misalign_err", 32'(ge), 32'd1);
    access(1, 0, F3_W, 32'(4*DEPTH), 32'd0, 0, g, ge);
    chk("lw_oob_err", 32'(ge), 32'd1);
    chk("lw_oob_rdata", g, 32'd0);
    access(1, 1, F3_W, 32'h10, 32'h11111111, 0, g, ge);
    chk("rw_both_err", 32'(ge), 32'd1);
    access(0, 1, F3_BU, 32'h10, 32'h22222222, 0, g, ge);
    chk("sbu_err", 32'(ge), 32'd1);
    access(1, 0, 3'b011, 32'h10, 32'd0, 0, g, ge);
    chk("f3_011_err", 32'(ge), 32'd1);
    access(1, 0, F3_W, 32'h10, 32'd0, 0, g, ge);
    chk("lw_after_errs", g, 32'hDEAD55EF);

    access(1, 0, F3_W, 32'h10, 32'd0, 5, g, ge);
    chk("lw_hold", g, 32'hDEAD55EF);
    access(1, 0, F3_W, 32'h10, 32'd0, 0, g, ge);
    chk("lw_after_hold", g, 32'hDEAD55EF);

    access(0, 1, F3_W, 32'h20, 32'd0, 0, g, ge);
    access(1, 0, F3_W, 32'h10, 32'd0, 0, g, ge);
    // Store aborted by reset while in ACCESS
    req_valid = 1'b1; is_memread = 1'b0; is_memwrite = 1'b1;
    funct3 = F3_W; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    busy = 1'b1;
    resp_at = cyc + WAIT + 1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    busy = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    access(1, 0, F3_W, 32'h20, 32'd0, 0, g, ge);
    chk("lw_20_after_rst", g, 32'h00000000);
    chk("lw_20_err", 32'(ge), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Data-memory responder for the core's load/store path; the completing end of the `is_memread`/`is_memwrite` requests raised by the control decoder. It accepts one access at a time over a valid/ready request channel, applies a programmable number of wait states, performs a byte/half/word read or write on an internal word-addressed array, and returns read data or an error over a valid/ready response channel. It sits between the execute stage (address from ALU, store data from rs2) and writeback (mem-to-reg path).

## Interface
- `DEPTH_WORDS`, 1024, number of 32-bit words; power of two, ≥ 4
- `WAIT_CYCLES`, 1, extra access latency in cycles, 0..15
- `clk_i`  in  1  clock, all logic on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  responder can accept a request
- `is_memread_i`  in  1  load request
- `is_memwrite_i`  in  1  store request
- `funct3_i`  in  3  access size/sign (RV32I load/store funct3)
- `addr_i`  in  32  byte address
- `wdata_i`  in  32  store data, right-aligned
- `resp_valid_o`  out  1  response present
- `resp_ready_i`  in  1  consumer takes response
- `rdata_o`  out  32  load data, extended; 0 for stores and errors
- `err_o`  out  1  access faulted; qualified by `resp_valid_o`

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE: `req_ready_o`=1. On `req_valid_i`, capture `is_memread_i`, `is_memwrite_i`, `funct3_i`, `addr_i`, `wdata_i`; load wait counter with `WAIT_CYCLES`; go to ACCESS.
- ACCESS: `req_ready_o`=0. Counter decrements each cycle. At counter==0, the next edge performs the access, registers `rdata_o`/`err_o`, and enters RESP.
- RESP: `resp_valid_o`=1; outputs held stable until `resp_ready_i`=1, then return to IDLE. No new request is accepted in the same cycle (one bubble).
- Sizes: funct3 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. LB/LH sign-extend; LBU/LHU zero-extend. Byte lane selected by `addr[1:0]`.
- Error (sets `err_o`=1, `rdata_o`=0, array unchanged) if any of the following holds:
  - both or neither of read/write is set;
  - funct3 is 011, 110 or 111;
  - a store uses funct3 100 or 101;
  - a half access has `addr[0]`=1;
  - a word access has `addr[1:0]`≠0;
  - the word index `addr[31:2]` ≥ `DEPTH_WORDS`.
- Stores write only the enabled byte lanes; other bytes are preserved.
- Array contents are not reset. The registered request fields reset to 0.

## Timing
- Reset values: `req_ready_o`=1, `resp_valid_o`=0, `rdata_o`=0, `err_o`=0.
- Latency: `resp_valid_o` rises exactly `WAIT_CYCLES`+1 cycles after the accepting edge. With `WAIT_CYCLES`=0, ACCESS lasts one cycle.
- A store commits on the edge entering RESP. A load accepted after that store's response returns the new data.
- Request inputs are ignored outside IDLE. Changes to them after acceptance have no effect.
- Reset during ACCESS: return to IDLE and commit no write. Reset during RESP: drop the response. A committed write remains in the array.
- Back-to-back throughput: one access per `WAIT_CYCLES`+3 cycles when `resp_ready_i` is held at 1.

## Structure
- The shared package `riscv_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the FSM state enum.
- Sub-module `mem_align` (combinational) implements:
  - the funct3/addr → 4-bit byte-enable and error decode;
  - store-data lane replication;
  - load lane extraction and extension.
- The top level holds the FSM, wait counter, request registers and array.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → resp `rdata_o`=0xDEADBEEF, `err_o`=0. Each `resp_valid_o` arrives `WAIT_CYCLES`+1 cycles after accept.
- After the previous store, LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 → 0xDEAD55EF.
- LW @0x12, SH @0x11, LW @(4·`DEPTH_WORDS`), and a request with both read and write set → each returns `err_o`=1, `rdata_o`=0. A following LW @0x10 shows the contents unchanged.
- Hold `resp_ready_i`=0 for 5 cycles in RESP → `resp_valid_o`, `rdata_o` and `err_o` stay stable, `req_ready_o`=0, and a new `req_valid_i` is not accepted. Release → IDLE next cycle.
- Assert `rst_i` mid-ACCESS of SW 0x12345678 @0x20, where the word was 0 → all outputs take reset values immediately. A subsequent LW @0x20 → 0x00000000.
